seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
Time-multiplexed driver for the board's 4-digit common-anode seven-segment display, sitting directly downstream of the counter and hex-to-7seg path. It replaces the static "all anodes on" drive with a scanned drive, so each digit shows an independent hex nibble of a 16-bit value. Values are double-buffered and swapped only at frame boundaries, so the display never tears. Leading-zero blanking, per-digit enable and per-digit decimal points are supported.

Parameters:
CRYSTAL, 50, input clock frequency in MHz.
REFRESH_HZ, 1000, digit-slot rate in Hz (frame rate = REFRESH_HZ/4).
DIG_PERIOD, CRYSTAL*1_000_000/REFRESH_HZ, clk cycles per digit slot; the bench overrides it, and it must be >= BLANK_CYCLES+2.
BLANK_CYCLES, 64, anti-ghosting dead time (all anodes off) at the start of each slot; must be >= 1.
PW, 16, prescaler width; must hold DIG_PERIOD-1.

Ports:
clk  in  1  system clock
arst  in  1  asynchronous reset, active-high
value_in  in  16  four hex nibbles; [3:0] is digit 0 (rightmost, an[0])
dp_in  in  4  decimal point per digit, 1 = lit
load  in  1  1-cycle strobe that captures value_in and dp_in into the pending buffer
digit_en  in  4  per-digit enable; 0 keeps that anode off for its whole slot
lzb  in  1  1 = leading-zero blanking
seg  out  7  segments a..g, seg[0]=a, active-low
dp  out  1  decimal point, active-low
an  out  4  anodes, active-low
frame_tick  out  1  1-cycle pulse at each frame boundary
pending  out  1  1 = a loaded value is still waiting for a frame boundary

Behaviour:
- Reset (asynchronous, immediate): an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0, pending=0. Prescaler=0, digit index=0, display and pending buffers=0.
- All outputs are registered.
- Prescaler counts 0..DIG_PERIOD-1 and wraps to 0. On each wrap the digit index advances 0->1->2->3->0.
- Frame boundary: prescaler wrap while digit index=3. On that cycle, frame_tick=1 for exactly one cycle.
- Slot phases by prescaler value p:
  - p < BLANK_CYCLES: an=1111, seg=1111111, dp=1.
  - otherwise: an has only bit [idx] low (if digit_en[idx]=1), seg=decode(nibble[idx]), dp=~dp_bit[idx].
- Output timing: outputs reflect the prescaler/index state with 1-cycle latency. The registered output is updated from the next-state p/idx, so the first lit cycle coincides with p==BLANK_CYCLES.
- Disabled digit: its slot still elapses (uniform brightness), but an stays 1111 for the whole slot.
- Decode (active-low, gfedcba order on seg[6:0]):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking: when lzb=1, digit k (k=3..1) is blanked if nibbles k..3 of the display buffer are all zero. A blanked digit drives seg=1111111 and an stays off. dp still follows dp_in for a blanked digit: the anode is turned on only if its dp bit=1. Digit 0 is never zero-blanked.
- Double buffer:
  - load=1 writes the pending buffer and sets pending=1. Back-to-back loads overwrite; the last one wins.
  - At a frame boundary with pending=1, the pending buffer is copied to the display buffer and pending clears.
  - Load on the same cycle as a boundary: the boundary copies the old pending contents. The new value stays pending (pending=1) and is displayed at the next boundary.
- lzb and digit_en are sampled live every cycle, not buffered.
- Reset mid-frame: immediate blank; scanning restarts at digit 0, p=0; pending data is discarded.

Test Plan:
1. DIG_PERIOD=16, BLANK_CYCLES=2; reset, then release -> an=1111 through p=0,1; then an=1110 for 14 cycles, 1101 after next blank, etc.; frame_tick every 64 cycles.
2. load value_in=16'h12AF, dp_in=4'b0100 mid-frame -> pending=1; old value (0000) shown until frame_tick. Next frame: digit0 seg=0001110 (F), digit1 0001000 (A), digit2 0100100 (2) with dp=0, digit3 1111001 (1); pending=0.
3. lzb=1, value=16'h0005 -> digits 3,2,1 an stay 1 for the full frame; digit0 shows 0010010. Repeat with value=16'h0000 -> only digit0 lit, showing 1000000.
4. digit_en=4'b1010, value=16'h8888 -> an never drives bits 0 or 2 low; slot timing unchanged (frame still 64 cycles).
5. load 16'h1111 asserted exactly on the frame-boundary cycle while pending holds 16'h2222 -> next frame shows 2222 with pending=1; the following frame shows 1111.
6. Assert arst mid-slot during digit 2 -> within the same cycle an=1111, seg=1111111, pending=0; after release, scanning resumes at digit 0 showing value 0000.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Scanned drive for a 4-digit common-anode seven-segment display.
// Values are double-buffered and swapped only at frame boundaries. Supports leading-zero blanking.
module seg7_scan_driver #(
  parameter int CRYSTAL      = 50,
  parameter int REFRESH_HZ   = 1000,
  parameter int DIG_PERIOD   = CRYSTAL * 1_000_000 / REFRESH_HZ,
  parameter int BLANK_CYCLES = 64,
  parameter int PW           = 16
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic [3:0]  digit_en,
  input  logic        lzb,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick,
  output logic        pending
);

  logic [PW-1:0] p_q, p_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [3:0]    pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic          pending_q, pending_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          ft_q, ft_d;

  logic          wrap, boundary, blanked, dp_bit;
  logic [3:0]    nib, lz;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    wrap     = (p_q == PW'(DIG_PERIOD - 1));
    boundary = wrap && (idx_q == 2'd3);
    p_d      = wrap ? '0 : p_q + 1'b1;
    idx_d    = wrap ? idx_q + 2'd1 : idx_q;

    // A load coinciding with a boundary wins pending; the copy uses the old buffer.
    pend_val_d = load ? value_in : pend_val_q;
    pend_dp_d  = load ? dp_in : pend_dp_q;
    pending_d  = load ? 1'b1 : (boundary ? 1'b0 : pending_q);
    disp_val_d = (boundary && pending_q) ? pend_val_q : disp_val_q;
    disp_dp_d  = (boundary && pending_q) ? pend_dp_q : disp_dp_q;

    lz[3] = (disp_val_q[15:12] == 4'h0);
    lz[2] = lz[3] && (disp_val_q[11:8] == 4'h0);
    lz[1] = lz[2] && (disp_val_q[7:4] == 4'h0);
    lz[0] = 1'b0;

    nib     = disp_val_q[{idx_d, 2'b00} +: 4];
    dp_bit  = disp_dp_q[idx_d];
    blanked = lzb && lz[idx_d];

    // Outputs are built from next-state p/idx so the register matches the counter.
    seg_d = '1;
    dp_d  = 1'b1;
    an_d  = '1;
    if (p_d >= PW'(BLANK_CYCLES)) begin
      seg_d = blanked ? 7'b1111111 : decode(nib);
      dp_d  = ~dp_bit;
      if (digit_en[idx_d] && (!blanked || dp_bit))
        an_d[idx_d] = 1'b0;
    end
    ft_d = boundary;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      p_q        <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      pending_q  <= 1'b0;
      seg_q      <= '1;
      dp_q       <= 1'b1;
      an_q       <= '1;
      ft_q       <= 1'b0;
    end else begin
      p_q        <= p_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      pending_q  <= pending_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      ft_q       <= ft_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = ft_q;
  assign pending    = pending_q;

endmodule
